// File: rtl/z80_idx_alu_seq.sv
// Sequencer for ADD/ADC/SUB/SBC/AND/XOR/OR/CP A,(IX/IY+d).
// It fetches d, forms the address, reads the operand, drives the ALU and commits A/F/IP.
module z80_idx_alu_seq #(
    parameter int ADDR_DELAY = 5,
    parameter int IP_STEP    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic        iy,
    input  logic [15:0] ip_in,
    input  logic [15:0] ix_in,
    input  logic [15:0] iy_in,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_valid,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  alu_flags,
    output logic        a_we,
    output logic [7:0]  a_out,
    output logic        f_we,
    output logic [7:0]  f_out,
    output logic        ip_we,
    output logic [15:0] ip_out,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_D = 3'd1;
    localparam logic [2:0] S_CALC    = 3'd2;
    localparam logic [2:0] S_READ_OP = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;

    localparam logic [3:0]  W_DELAY = 4'(ADDR_DELAY);
    localparam logic [15:0] W_STEP  = 16'(IP_STEP);
    localparam logic [2:0]  OP_CP   = 3'b111;

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_alu_op;
    logic [15:0] r_base;
    logic [15:0] r_fetch_addr;
    logic [15:0] r_ip_out;
    logic [15:0] r_ea;
    logic [7:0]  r_a;
    logic        r_cin;
    logic [7:0]  r_b;
    logic [7:0]  r_res;
    logic [7:0]  r_flags;

    logic [15:0] w_disp;
    logic        w_unused;

    assign w_disp   = {{8{mem_rdata[7]}}, mem_rdata};
    assign w_unused = &{1'b0, opcode[7:6], opcode[2:0], f_in[7:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_alu_op     <= 3'd0;
            r_base       <= 16'd0;
            r_fetch_addr <= 16'd0;
            r_ip_out     <= 16'd0;
            r_ea         <= 16'd0;
            r_a          <= 8'd0;
            r_cin        <= 1'b0;
            r_b          <= 8'd0;
            r_res        <= 8'd0;
            r_flags      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_alu_op     <= opcode[5:3];
                        r_base       <= iy ? iy_in : ix_in;
                        r_fetch_addr <= ip_in + 16'd2;
                        r_ip_out     <= ip_in + W_STEP;
                        r_a          <= a_in;
                        r_cin        <= f_in[0];
                        r_state      <= S_FETCH_D;
                    end
                end
                S_FETCH_D: begin
                    if (mem_ack) begin
                        r_ea    <= r_base + w_disp;
                        r_cnt   <= W_DELAY;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Exiting at 1 (not 0) gives max(ADDR_DELAY,1) cycles in CALC.
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_READ_OP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_READ_OP: begin
                    if (mem_ack) begin
                        r_b     <= mem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res   <= alu_result;
                    r_flags <= alu_flags;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode from state only, so reset drops the request at once.
    assign mem_rd_req = (r_state == S_FETCH_D) || (r_state == S_READ_OP);
    assign mem_addr   = (r_state == S_FETCH_D) ? r_fetch_addr :
                        (r_state == S_READ_OP) ? r_ea : 16'd0;

    assign alu_op    = r_alu_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_cin   = r_cin;
    assign alu_valid = (r_state == S_EXEC);

    assign done   = (r_state == S_WB);
    assign f_we   = done;
    assign ip_we  = done;
    assign a_we   = done && (r_alu_op != OP_CP);
    assign a_out  = r_res;
    assign f_out  = r_flags;
    assign ip_out = r_ip_out;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_z80_idx_alu_seq.sv
// Directed bench for z80_idx_alu_seq: default-delay DUT with a wait-state memory
// responder and address scoreboard, plus an ADDR_DELAY=0 DUT with zero-wait memory.
module tb_z80_idx_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'd0;
    logic        iy = 1'b0;
    logic [15:0] ip_in = 16'd0, ix_in = 16'd0, iy_in = 16'd0;
    logic [7:0]  a_in = 8'd0, f_in = 8'd0;
    logic        mem_rd_req, mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_result, alu_flags;
    logic        alu_cin, alu_valid;
    logic        a_we, f_we, ip_we, busy, done;
    logic [7:0]  a_out, f_out;
    logic [15:0] ip_out;

    logic        start0 = 1'b0;
    logic        mem_rd_req0, mem_ack0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_rdata0;
    logic [2:0]  alu_op0;
    logic [7:0]  alu_a0, alu_b0, alu_result0, alu_flags0;
    logic        alu_cin0, alu_valid0;
    logic        a_we0, f_we0, ip_we0, busy0, done0;
    logic [7:0]  a_out0, f_out0;
    logic [15:0] ip_out0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_q[$];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          wb_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [2:0]  x_op;
    logic [7:0]  x_a, x_b;
    logic        x_cin;

    // clock / reset
    always #5 clk = ~clk;

    // Reference ALU: returns {flags, result}, flags = {S, Z, 0000, N, C}.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic       n;
        s = 9'd0;
        n = (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
        case (op)
            3'd0: s = {1'b0, a} + {1'b0, b};
            3'd1: s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'd2: s = {1'b0, a} - {1'b0, b};
            3'd3: s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            3'd4: s = {1'b0, a & b};
            3'd5: s = {1'b0, a ^ b};
            3'd6: s = {1'b0, a | b};
            default: s = {1'b0, a} - {1'b0, b};
        endcase
        return {s[7], (s[7:0] == 8'd0), 4'b0000, n, s[8], s[7:0]};
    endfunction

    assign {alu_flags, alu_result}   = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    assign {alu_flags0, alu_result0} = alu_fn(alu_op0, alu_a0, alu_b0, alu_cin0);
    assign mem_ack0   = mem_rd_req0;
    assign mem_rdata0 = mem[mem_addr0];

    z80_idx_alu_seq u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .iy(iy),
        .ip_in(ip_in), .ix_in(ix_in), .iy_in(iy_in), .a_in(a_in), .f_in(f_in),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_valid(alu_valid),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .a_we(a_we), .a_out(a_out), .f_we(f_we), .f_out(f_out), .ip_we(ip_we), .ip_out(ip_out),
        .busy(busy), .done(done)
    );

    z80_idx_alu_seq #(.ADDR_DELAY(0), .IP_STEP(3)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .opcode(opcode), .iy(iy),
        .ip_in(ip_in), .ix_in(ix_in), .iy_in(iy_in), .a_in(a_in), .f_in(f_in),
        .mem_rd_req(mem_rd_req0), .mem_addr(mem_addr0), .mem_ack(mem_ack0), .mem_rdata(mem_rdata0),
        .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_cin(alu_cin0), .alu_valid(alu_valid0),
        .alu_result(alu_result0), .alu_flags(alu_flags0),
        .a_we(a_we0), .a_out(a_out0), .f_we(f_we0), .f_out(f_out0), .ip_we(ip_we0), .ip_out(ip_out0),
        .busy(busy0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: checks the address (every waiting cycle too) against the expected queue.
    always @(negedge clk) begin
        if (!reset_n || !mem_rd_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (exp_q.size() == 0) check("rd_unexpected", {16'd0, mem_addr}, 32'hFFFF_FFFF);
            else                   check("rd_addr", {16'd0, mem_addr}, {16'd0, exp_q[0]});
            if (wait_cnt >= ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (a_we || f_we || ip_we || done) wb_cnt++;
    end

    // Launches one instruction on u_dut; returns the cycle in which done was seen.
    task automatic run(input logic [7:0] op, input logic use_iy, input logic [15:0] ip,
                       input logic [15:0] ix, input logic [15:0] iyv, input logic [7:0] a,
                       input logic [7:0] f, input int stray, output int cyc);
        @(negedge clk);
        opcode = op; iy = use_iy; ip_in = ip; ix_in = ix; iy_in = iyv; a_in = a; f_in = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (alu_valid) begin
                x_op = alu_op; x_a = alu_a; x_b = alu_b; x_cin = alu_cin;
            end
            if (cyc == stray) begin
                start = 1'b1;
                opcode = 8'hA6;
                a_in = 8'hEE;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        if (cyc >= 200) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        int wb_before;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0202] = 8'hFE; mem[16'h0FFE] = 8'h22;
        mem[16'h0302] = 8'h02; mem[16'h0001] = 8'h05;
        mem[16'h0402] = 8'h10; mem[16'h2010] = 8'h20;
        mem[16'h0502] = 8'h80; mem[16'h2F80] = 8'h20;

        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_req",    {31'd0, mem_rd_req}, 32'd0);
        check("rst_addr",   {16'd0, mem_addr}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_ip_out", {16'd0, ip_out}, 32'd0);
        check("rst_a_out",  {24'd0, a_out}, 32'd0);
        reset_n = 1'b1;

        // ADD A,(IX-2), zero-wait
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0FFE);
        run(8'h86, 1'b0, 16'h0200, 16'h1000, 16'h0000, 8'h10, 8'h00, 0, cyc);
        check("add_cycle",  cyc, 9);
        check("add_a_we",   {31'd0, a_we}, 32'd1);
        check("add_a_out",  {24'd0, a_out}, 32'h32);
        check("add_f_out",  {24'd0, f_out}, 32'h00);
        check("add_ip_out", {16'd0, ip_out}, 32'h0203);
        check("add_ip_we",  {31'd0, ip_we}, 32'd1);
        check("add_alu_op", {29'd0, x_op}, 32'd0);
        check("add_alu_a",  {24'd0, x_a}, 32'h10);
        check("add_alu_b",  {24'd0, x_b}, 32'h22);
        check("add_reads",  exp_q.size(), 0);

        // CP A,(IY+2) with IY wrapping to 0x0001
        exp_q.push_back(16'h0302); exp_q.push_back(16'h0001);
        run(8'hBE, 1'b1, 16'h0300, 16'h1234, 16'hFFFF, 8'h05, 8'h00, 0, cyc);
        check("cp_cycle",  cyc, 9);
        check("cp_a_we",   {31'd0, a_we}, 32'd0);
        check("cp_f_we",   {31'd0, f_we}, 32'd1);
        check("cp_f_out",  {24'd0, f_out}, 32'h42);
        check("cp_ip_out", {16'd0, ip_out}, 32'h0303);
        check("cp_reads",  exp_q.size(), 0);

        // ADC with carry in and 3 wait states per read
        ack_wait = 3;
        exp_q.push_back(16'h0402); exp_q.push_back(16'h2010);
        run(8'h8E, 1'b0, 16'h0400, 16'h2000, 16'h0000, 8'hF0, 8'h01, 0, cyc);
        ack_wait = 0;
        check("adc_cycle",  cyc, 15);
        check("adc_alu_op", {29'd0, x_op}, 32'd1);
        check("adc_cin",    {31'd0, x_cin}, 32'd1);
        check("adc_a_out",  {24'd0, a_out}, 32'h11);
        check("adc_f_out",  {24'd0, f_out}, 32'h01);
        check("adc_ip_out", {16'd0, ip_out}, 32'h0403);
        check("adc_reads",  exp_q.size(), 0);

        // SUB on the ADDR_DELAY=0 instance, d=0x80 (negative)
        @(negedge clk);
        opcode = 8'h96; iy = 1'b0; ip_in = 16'h0500; ix_in = 16'h3000; a_in = 8'h10; f_in = 8'h00;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done0) break;
        end
        check("sub0_cycle",  cyc, 5);
        check("sub0_a_out",  {24'd0, a_out0}, 32'hF0);
        check("sub0_f_out",  {24'd0, f_out0}, 32'h83);
        check("sub0_ip_out", {16'd0, ip_out0}, 32'h0503);

        // Reset while READ_OP waits for ack
        ack_wait = 10;
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0FFE);
        wb_before = wb_cnt;
        @(negedge clk);
        opcode = 8'h86; iy = 1'b0; ip_in = 16'h0200; ix_in = 16'h1000; a_in = 8'h10; f_in = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 60 && !(mem_rd_req && mem_addr == 16'h0FFE)) begin
            @(negedge clk);
            cyc++;
        end
        check("rmid_reached", {31'd0, (cyc < 60)}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rmid_req",  {31'd0, mem_rd_req}, 32'd0);
        check("rmid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rmid_no_wb", wb_cnt, wb_before);
        reset_n = 1'b1;
        ack_wait = 0;
        @(negedge clk);
        check("rmid_idle", {31'd0, busy}, 32'd0);
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0FFE);
        run(8'h86, 1'b0, 16'h0200, 16'h1000, 16'h0000, 8'h10, 8'h00, 0, cyc);
        check("rmid_cycle", cyc, 9);
        check("rmid_a_out", {24'd0, a_out}, 32'h32);

        // Stray start while busy, then back-to-back launch in the cycle after WB
        exp_q.push_back(16'h0302); exp_q.push_back(16'h0001);
        run(8'hBE, 1'b1, 16'h0300, 16'h1234, 16'hFFFF, 8'h05, 8'h00, 3, cyc);
        check("b2b1_cycle", cyc, 9);
        check("b2b1_a_we",  {31'd0, a_we}, 32'd0);
        check("b2b1_f_out", {24'd0, f_out}, 32'h42);
        exp_q.push_back(16'h0202); exp_q.push_back(16'h0FFE);
        run(8'h86, 1'b0, 16'h0200, 16'h1000, 16'h0000, 8'h10, 8'h00, 0, cyc);
        check("b2b2_cycle", cyc, 9);
        check("b2b2_a_out", {24'd0, a_out}, 32'h32);
        check("b2b2_reads", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
